nes_pad_reader: RTL and testbench

- Serial reader for a standard NES controller (4021 shift register). Produces the 8-bit `key` bus consumed by the exec_nes core's `key` input.
- Periodically pulses `pad_latch`, then clocks out 8 button bits with `pad_clk`. Each bit is synchronised and sampled, then published as an active-high button vector with a one-cycle valid strobe.
- Sits upstream of the core in the NES top level; runs on `clk`, the same clock as exec_nes.

---
 rtl/nes_pad_pkg.sv | 23 ++
 rtl/pad_sync.sv | 22 ++
 rtl/nes_pad_reader.sv | 145 ++++++++++++++
 tb/tb_nes_pad_reader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/nes_pad_pkg.sv
// Shared types and constants for the NES controller reader.
package nes_pad_pkg;

  localparam int KEY_W = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchroniser for the asynchronous pad data line.
// Resets to 1 so that an idle (released) line reads as "not pressed".
module pad_sync (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_pad_reader.sv
// Polls a 4021-based NES pad once per poll period and publishes the 8 buttons
// as an active-high vector with a one-cycle key_valid strobe.
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int POLL_CYCLES     = 833333,
  parameter int LATCH_CYCLES    = 600,
  parameter int HALF_BIT_CYCLES = 300
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             pad_data,
  output logic             pad_latch,
  output logic             pad_clk,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output state_t           dbg_state
);

  localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TC_MAX = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES : HALF_BIT_CYCLES;
  localparam int TCNT_W = $clog2(TC_MAX + 1);

  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
  localparam logic [TCNT_W-1:0] LATCH_LAST = TCNT_W'(LATCH_CYCLES - 1);
  localparam logic [TCNT_W-1:0] HALF_LAST  = TCNT_W'(HALF_BIT_CYCLES - 1);

  logic              pad_q;
  logic [POLL_W-1:0] poll_cnt;
  logic              poll_wrap;
  logic              pending;

  state_t            state, state_n;
  logic [TCNT_W-1:0] tcnt, tcnt_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [KEY_W-1:0]  shift, shift_n;
  logic              frame_start;
  logic              load_key;

  pad_sync u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (pad_data),
    .q      (pad_q)
  );

  // Poll timer runs regardless of state; a wrap while pending is already set is absorbed.
  assign poll_wrap = (poll_cnt == POLL_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      poll_cnt <= '0;
      pending  <= 1'b0;
    end else begin
      poll_cnt <= poll_wrap ? '0 : poll_cnt + 1'b1;
      if (frame_start)
        pending <= 1'b0;
      else if (poll_wrap)
        pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      tcnt    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      tcnt    <= tcnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
    end
  end

  always_comb begin
    state_n     = state;
    tcnt_n      = tcnt + 1'b1;
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    frame_start = 1'b0;
    load_key    = 1'b0;
    case (state)
      IDLE: begin
        tcnt_n = '0;
        if (pending && enable) begin
          state_n     = LATCH;
          frame_start = 1'b1;
        end
      end
      LATCH: begin
        if (tcnt == LATCH_LAST) begin
          state_n   = LOW;
          tcnt_n    = '0;
          bit_idx_n = '0;
        end
      end
      LOW: begin
        // Sample at the end of the low phase so the synchroniser has settled.
        if (tcnt == HALF_LAST) begin
          shift_n[bit_idx] = ~pad_q;
          tcnt_n           = '0;
          state_n          = (bit_idx == 3'd7) ? DONE : HIGH;
        end
      end
      HIGH: begin
        if (tcnt == HALF_LAST) begin
          tcnt_n    = '0;
          bit_idx_n = bit_idx + 1'b1;
          state_n   = LOW;
        end
      end
      DONE: begin
        tcnt_n   = '0;
        load_key = 1'b1;
        state_n  = IDLE;
      end
      default: begin
        tcnt_n  = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Pad strobes are registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
      key       <= '0;
      key_valid <= 1'b0;
    end else begin
      pad_latch <= (state_n == LATCH);
      pad_clk   <= (state_n == HIGH);
      key_valid <= load_key;
      if (load_key)
        key <= shift;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader with a behavioural 4021 pad model.
module tb_nes_pad_reader;
  import nes_pad_pkg::*;

  localparam int POLL  = 200;
  localparam int LATCH = 4;
  localparam int HALF  = 4;
  localparam int FRAME = LATCH + 15 * HALF + 1;
  localparam int LIMIT = 1000;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b1;
  logic       pad_data;
  logic       pad_latch, pad_clk, key_valid;
  logic [7:0] key;
  state_t     dbg_state;

  logic [7:0] btn = 8'h00;
  logic [7:0] sr = 8'h00;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];

  nes_pad_reader #(
    .POLL_CYCLES     (POLL),
    .LATCH_CYCLES    (LATCH),
    .HALF_BIT_CYCLES (HALF)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .pad_data  (pad_data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .key       (key),
    .key_valid (key_valid),
    .dbg_state (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 4021 model: parallel load while latched, shift on pad_clk rise, active-low output
  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) sr <= btn;
    else           sr <= {1'b0, sr[7:1]};
  end
  assign pad_data = ~sr[0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  int   latch_rises = 0, latch_rise_cyc = 0, latch_len = 0, clk_rises = 0;
  int   kv_count = 0, kv_cyc = 0;
  logic prev_latch = 1'b0, prev_pclk = 1'b0, prev_kv = 1'b0, prev_rst = 1'b0;
  logic [7:0] prev_key = 8'h00;

  always @(negedge clk) begin
    if (pad_latch && !prev_latch) begin
      latch_rises++;
      latch_rise_cyc = cyc;
      latch_len = 1;
      clk_rises = 0;
    end else if (pad_latch) begin
      latch_len++;
    end
    if (pad_clk && !prev_pclk) clk_rises++;
    if (resetn && prev_rst && !key_valid) chk("key_stable", 32'(key), 32'(prev_key));
    if (resetn && key_valid) begin
      chk("kv_double", 32'(prev_kv), 32'd0);
      kv_count++;
      kv_cyc = cyc;
      if (exp_q.size() == 0) chk("kv_unexpected", 32'(key_valid), 32'd0);
      else                   chk("key", 32'(key), 32'(exp_q.pop_front()));
    end
    prev_latch = pad_latch;
    prev_pclk  = pad_clk;
    prev_kv    = key_valid;
    prev_key   = key;
    prev_rst   = resetn;
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_latch();
    int n0 = latch_rises;
    int t = 0;
    while (latch_rises == n0 && t < LIMIT) begin tick(); t++; end
    chk("latch_timeout", 32'(latch_rises != n0), 32'd1);
  endtask

  task automatic wait_kv();
    int n0 = kv_count;
    int t = 0;
    while (kv_count == n0 && t < LIMIT) begin tick(); t++; end
    chk("kv_timeout", 32'(kv_count != n0), 32'd1);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset(input int hold, output int rel);
    resetn = 1'b0;
    repeat (hold) tick();
    resetn = 1'b1;
    rel = cyc + 1;
  endtask

  task automatic run_frame(input logic [7:0] b);
    btn = b;
    exp_q.push_back(b);
    wait_kv();
  endtask

  initial begin
    int rel, e, n, kv0;

    // reset state and first frame: A + Start + Right
    tick();
    resetn = 1'b0;
    repeat (4) tick();
    chk("rst_latch", 32'(pad_latch), 32'd0);
    chk("rst_pclk", 32'(pad_clk), 32'd0);
    chk("rst_key", 32'(key), 32'd0);
    chk("rst_kv", 32'(key_valid), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    btn = 8'h89;
    exp_q.push_back(8'h89);
    resetn = 1'b1;
    rel = cyc + 1;
    wait_latch();
    chk("first_latch_delay", 32'(latch_rise_cyc - rel), 32'(POLL));
    wait_kv();
    chk("latch_width", 32'(latch_len), 32'(LATCH));
    chk("pclk_rises", 32'(clk_rises), 32'd7);
    chk("kv_delay", 32'(kv_cyc - latch_rise_cyc), 32'(FRAME));
    chk("key_hold", 32'(key), 32'h89);

    // data patterns
    run_frame(8'h00);
    run_frame(8'hFF);
    run_frame(8'h55);
    run_frame(8'hAA);
    chk("key_after_aa", 32'(key), 32'hAA);

    // enable dropped during bit 3: frame completes, then no further polling
    btn = 8'h3C;
    exp_q.push_back(8'h3C);
    wait_latch();
    e = latch_rise_cyc;
    wait_until(e + 30);
    enable = 1'b0;
    wait_kv();
    n = latch_rises;
    repeat (450) tick();
    chk("no_latch_disabled", 32'(latch_rises), 32'(n));
    chk("key_held_disabled", 32'(key), 32'h3C);

    // enable low from reset, raised at cycle 500 with pending already held
    do_reset(3, rel);
    n = latch_rises;
    wait_until(rel + 499);
    chk("no_latch_from_rst", 32'(latch_rises), 32'(n));
    chk("key_zero_disabled", 32'(key), 32'd0);
    btn = 8'h12;
    exp_q.push_back(8'h12);
    enable = 1'b1;
    e = cyc + 1;
    wait_latch();
    chk("enable_latch_cycle", 32'(latch_rise_cyc), 32'(e));
    wait_kv();

    // reset during HIGH of bit 4 aborts the frame
    btn = 8'hF0;
    wait_latch();
    e = latch_rise_cyc;
    wait_until(e + 42);
    chk("in_high_bit4", 32'(pad_clk), 32'd1);
    kv0 = kv_count;
    resetn = 1'b0;
    tick();
    chk("abort_pclk", 32'(pad_clk), 32'd0);
    chk("abort_latch", 32'(pad_latch), 32'd0);
    chk("abort_key", 32'(key), 32'd0);
    repeat (2) tick();
    resetn = 1'b1;
    rel = cyc + 1;
    exp_q.push_back(8'hF0);
    wait_latch();
    chk("abort_no_kv", 32'(kv_count), 32'(kv0));
    chk("relatch_delay", 32'(latch_rise_cyc - rel), 32'(POLL));
    wait_kv();

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
